conv_mac_acc: RTL and testbench
===============================

# conv_mac_acc

Pipelined, parametrised 3x3 convolution MAC for the CNN datapath. It accumulates one 3x3 window across `CHANNELS` input channels, then adds a bias, requantises (rounding shift, optional ReLU, saturation) and emits one `OUT_BITS` activation per output pixel. It sits between the line-buffer/window generator and the activation store. It adds a valid/ready backpressure path and a pipelined datapath.

## Interface
- `DATA_BITS`, 8, signed pixel width
- `WEIGHT_BITS`, 8, signed weight width
- `ACC_BITS`, 32, accumulator and bias width
- `CHANNELS`, 4, input channels per output pixel (>=1)
- `OUT_BITS`, 8, signed output width
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `valid_in`  in  1  window beat valid
- `in_ready`  out  1  block accepts a beat this cycle
- `pix`  in  9*DATA_BITS  window p00..p22, p00 in LSBs, row-major
- `wgt`  in  9*WEIGHT_BITS  kernel k00..k22, same packing
- `bias`  in  ACC_BITS  signed bias
- `shift`  in  5  requant right-shift, 0..31
- `relu_en`  in  1  clamp negatives to 0
- `ch_idx`  out  clog2(CHANNELS) (min 1)  channel index of next beat to accept
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `out_data`  out  OUT_BITS  signed activation
- `out_sat`  out  1  saturation occurred on `out_data`

## Operation
- Accept: beat accepted when `valid_in && in_ready`. `ch_idx` increments per accepted beat, wraps CHANNELS-1 -> 0. A beat with `ch_idx==CHANNELS-1` is "last". With CHANNELS=1, every beat is last.
- Stall: `stall = out_valid && !out_ready`. `in_ready = !stall`. While stalled, S1, S2, accumulator, counter and output all hold.
- S1 (edge after accept): nine signed products, DATA_BITS+WEIGHT_BITS wide, registered with valid and last flags.
- S2: sign-extended sum of the 9 products to ACC_BITS, registered with valid and last flags.
- S3: on S2 valid and not last, `acc <= acc + sum`.
- S3: on S2 valid and last, compute `t = acc + sum + bias`, load the output register, and clear `acc` to 0.
- All ACC_BITS arithmetic wraps (two's complement).
- Requant: if shift>0, `r = (t + (1<<(shift-1))) >>> shift`; else `r = t`.
- If `relu_en` and r<0, r=0.
- Saturate r to [-(2^(OUT_BITS-1)), 2^(OUT_BITS-1)-1]. `out_sat`=1 iff clamping changed r.
- `bias`, `shift` and `relu_en` are sampled on the edge that loads the output. Upstream holds them stable per output pixel.
- Output handshake: `out_valid` rises on the output load and stays high until `out_ready`. A transfer completes on `out_valid && out_ready`. On that edge, a new last beat in S2 may load the next result the same edge; no bubble.
- Bubbles (valid_in low): S1/S2 valid flags go low; counter and accumulator are untouched.
- Reset: all registers cleared asynchronously. `in_ready` follows stall=0, i.e. is 1 after reset.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_sat`=0, `ch_idx`=0, `in_ready`=1. Accumulator and pipeline valid flags are 0.
- Latency: last beat accepted at edge E0 -> S1 at E0, S2 at E1, `out_valid`=1 after E2 (3 cycles, no stall).
- Throughput: one beat per cycle; one result per CHANNELS beats.
- Stall cycles add exactly 1:1 latency.
- `in_ready` is combinational from `out_valid` and `out_ready` only.
- Reset mid-frame discards the partial accumulation and in-flight beats. The next accepted beat is channel 0.

## Test plan
- CHANNELS=1; all pix=1, wgt=1, bias=0, shift=0, relu_en=0; one beat -> out_valid 3 cycles after accept, out_data=9, out_sat=0.
- CHANNELS=4; pix=10, wgt=2 for 4 back-to-back beats; bias=-20; shift=2 -> t=700, r=175, out_data=127, out_sat=1; ch_idx sequence 0,1,2,3,0.
- CHANNELS=1; pix=-5, wgt=3; shift=1; relu_en=0 -> t=-135, out_data=-67.
- Same stimulus with shift=0: relu_en=0 -> out_data=-128, out_sat=1; relu_en=1 -> out_data=0, out_sat=0.
- Backpressure: continuous CHANNELS=1 stream of distinct windows, out_ready held low 5 cycles -> in_ready low while out_valid high, out_data stable. On release, results are in order, none lost or duplicated; scoreboard vs model.
- Bubbles and reset:
  - Random valid_in gaps over CHANNELS=4 frames -> results identical to back-to-back.
  - Assert rst_n low after 2 of 4 beats -> outputs reset values. The next 4 beats yield a clean result matching model without the 2 discarded beats.

Source files
------------

// File: rtl/conv_mac_acc.sv
// conv_mac_acc: pipelined 3x3 conv MAC accumulating CHANNELS beats, then bias, rounding shift, ReLU and saturation.
// Three stages (products, tree sum, accumulate/requant) all freeze while the output is stalled.
module conv_mac_acc #(
    parameter int DATA_BITS   = 8,
    parameter int WEIGHT_BITS = 8,
    parameter int ACC_BITS    = 32,
    parameter int CHANNELS    = 4,
    parameter int OUT_BITS    = 8
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           valid_in,
    output logic                                           in_ready,
    input  logic [9*DATA_BITS-1:0]                         pix,
    input  logic [9*WEIGHT_BITS-1:0]                       wgt,
    input  logic signed [ACC_BITS-1:0]                     bias,
    input  logic [4:0]                                     shift,
    input  logic                                           relu_en,
    output logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] ch_idx,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [OUT_BITS-1:0]                            out_data,
    output logic                                           out_sat
);
    localparam int PW = DATA_BITS + WEIGHT_BITS;
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam logic signed [ACC_BITS-1:0] OMAX = {{(ACC_BITS-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] OMIN = ~OMAX;

    logic signed [PW-1:0]       prod_q [9];
    logic signed [PW-1:0]       prod_d [9];
    logic                       s1_v_q, s1_v_d, s1_last_q, s1_last_d;
    logic                       s2_v_q, s2_v_d, s2_last_q, s2_last_d;
    logic signed [ACC_BITS-1:0] sum_q, sum_d, sum_c, acc_q, acc_d;
    logic signed [ACC_BITS-1:0] t, rnd, r, rr;
    logic [CW-1:0]              ch_q, ch_d;
    logic [OUT_BITS-1:0]        out_data_q, out_data_d;
    logic                       out_valid_q, out_valid_d, out_sat_q, out_sat_d;
    logic                       stall, accept, last, load, hi, lo;

    always_comb begin
        stall = out_valid_q && !out_ready;
        accept = valid_in && !stall;
        last = ch_q == CW'(CHANNELS - 1);
        ch_d = accept ? (last ? '0 : ch_q + CW'(1)) : ch_q;
        for (int k = 0; k < 9; k++)
            prod_d[k] = accept ? PW'($signed(pix[k*DATA_BITS +: DATA_BITS])) *
                                 PW'($signed(wgt[k*WEIGHT_BITS +: WEIGHT_BITS])) : prod_q[k];
        s1_v_d = stall ? s1_v_q : accept;
        s1_last_d = stall ? s1_last_q : accept && last;
        sum_c = '0;
        for (int k = 0; k < 9; k++)
            sum_c = sum_c + ACC_BITS'(prod_q[k]);
        sum_d = (!stall && s1_v_q) ? sum_c : sum_q;
        s2_v_d = stall ? s2_v_q : s1_v_q;
        s2_last_d = stall ? s2_last_q : s1_v_q && s1_last_q;
        load = !stall && s2_v_q && s2_last_q;
        acc_d = load ? '0 : (!stall && s2_v_q) ? acc_q + sum_q : acc_q;
        t = acc_q + sum_q + bias;
        // Logical >> keeps the half-LSB positive even for shift=31; shift=0 yields zero.
        rnd = (ACC_BITS'(1) << shift) >> 1;
        r = (t + rnd) >>> shift;
        rr = (relu_en && r[ACC_BITS-1]) ? '0 : r;
        hi = rr > OMAX;
        lo = rr < OMIN;
        out_data_d = load ? (hi ? OMAX[OUT_BITS-1:0] : lo ? OMIN[OUT_BITS-1:0] : rr[OUT_BITS-1:0]) : out_data_q;
        out_sat_d = load ? (hi || lo) : out_sat_q;
        out_valid_d = load || stall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++)
                prod_q[k] <= '0;
            s1_v_q <= 1'b0;
            s1_last_q <= 1'b0;
            s2_v_q <= 1'b0;
            s2_last_q <= 1'b0;
            sum_q <= '0;
            acc_q <= '0;
            ch_q <= '0;
            out_data_q <= '0;
            out_valid_q <= 1'b0;
            out_sat_q <= 1'b0;
        end else begin
            for (int k = 0; k < 9; k++)
                prod_q[k] <= prod_d[k];
            s1_v_q <= s1_v_d;
            s1_last_q <= s1_last_d;
            s2_v_q <= s2_v_d;
            s2_last_q <= s2_last_d;
            sum_q <= sum_d;
            acc_q <= acc_d;
            ch_q <= ch_d;
            out_data_q <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sat_q <= out_sat_d;
        end
    end

    assign in_ready = !stall;
    assign ch_idx = ch_q;
    assign out_valid = out_valid_q;
    assign out_data = out_data_q;
    assign out_sat = out_sat_q;
endmodule

// File: tb/tb_conv_mac_acc.sv
// tb_conv_mac_acc: directed bench for conv_mac_acc with CHANNELS=1 and CHANNELS=4 instances.
module tb_conv_mac_acc;
    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [71:0]        pix = '0;
    logic [71:0]        wgt = '0;
    logic signed [31:0] bias = '0;
    logic [4:0]         sh = '0;
    logic               relu = 1'b0;
    logic               out_ready = 1'b1;
    logic               v1 = 1'b0, v4 = 1'b0;
    logic               ir1, ov1, os1, ir4, ov4, os4;
    logic [0:0]         ch1;
    logic [1:0]         ch4;
    logic [7:0]         od1, od4;
    int                 checks = 0;
    int                 fails = 0;

    always #5 clk = ~clk;

    conv_mac_acc #(.CHANNELS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .valid_in(v1), .in_ready(ir1), .pix(pix), .wgt(wgt),
        .bias(bias), .shift(sh), .relu_en(relu), .ch_idx(ch1), .out_valid(ov1),
        .out_ready(out_ready), .out_data(od1), .out_sat(os1)
    );

    conv_mac_acc #(.CHANNELS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .valid_in(v4), .in_ready(ir4), .pix(pix), .wgt(wgt),
        .bias(bias), .shift(sh), .relu_en(relu), .ch_idx(ch4), .out_valid(ov4),
        .out_ready(out_ready), .out_data(od4), .out_sat(os4)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] mkpix(input int i);
        logic [71:0] p;
        for (int j = 0; j < 9; j++)
            p[j*8 +: 8] = 8'(((i * 5 + j * 11) % 23) - 11);
        return p;
    endfunction

    function automatic logic [71:0] mkwgt(input int i);
        logic [71:0] w;
        for (int j = 0; j < 9; j++)
            w[j*8 +: 8] = 8'(((i * 3 + j * 7) % 13) - 6);
        return w;
    endfunction

    function automatic longint dot(input logic [71:0] p, input logic [71:0] w);
        longint s = 0;
        for (int j = 0; j < 9; j++)
            s += longint'($signed(p[j*8 +: 8])) * longint'($signed(w[j*8 +: 8]));
        return s;
    endfunction

    // {sat, data}: rounding shift, optional ReLU, clamp to signed 8 bits
    function automatic logic [8:0] rq(input longint t, input int s, input bit re);
        longint r;
        r = s > 0 ? (t + (longint'(1) << (s - 1))) >>> s : t;
        if (re && r < 0) r = 0;
        if (r > 127) return {1'b1, 8'd127};
        if (r < -128) return {1'b1, 8'h80};
        return {1'b0, 8'(r)};
    endfunction

    task automatic send(input bit four, input logic [71:0] p, input logic [71:0] w);
        bit rdy = 1'b0;
        int n = 0;
        pix = p;
        wgt = w;
        if (four) v4 = 1'b1; else v1 = 1'b1;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = four ? ir4 : ir1;
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy) chk("send_timeout", 0, 1);
        v1 = 1'b0;
        v4 = 1'b0;
    endtask

    task automatic wait_ov(input bit four);
        int n = 0;
        while (!(four ? ov4 : ov1) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 20) chk("ov_timeout", 0, 1);
    endtask

    task automatic one1(input string tag, input logic [4:0] s, input bit re, input int ed, input int es);
        sh = s;
        relu = re;
        send(1'b0, {9{8'hFB}}, {9{8'h03}});
        wait_ov(1'b0);
        chk({tag, "_data"}, $signed(od1), ed);
        chk({tag, "_sat"}, os1, es);
    endtask

    task automatic frame4(input string tag, input int base, input bit gaps);
        longint s = 0;
        logic [8:0] e;
        for (int i = 0; i < 4; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            send(1'b1, mkpix(base + i), mkwgt(base + i));
            s += dot(mkpix(base + i), mkwgt(base + i));
        end
        wait_ov(1'b1);
        e = rq(s + longint'(bias), int'(sh), relu);
        chk({tag, "_data"}, $signed(od4), $signed(e[7:0]));
        chk({tag, "_sat"}, os4, e[8]);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ov1", ov1, 0);
        chk("rst_od1", od1, 0);
        chk("rst_os1", os1, 0);
        chk("rst_ir1", ir1, 1);
        chk("rst_ch4", ch4, 0);
        chk("rst_ov4", ov4, 0);
        chk("rst_ir4", ir4, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single-channel latency: out_valid appears on the third edge after accept
        send(1'b0, {9{8'h01}}, {9{8'h01}});
        chk("lat_e0", ov1, 0);
        @(posedge clk); #1;
        chk("lat_e1", ov1, 0);
        @(posedge clk); #1;
        chk("lat_e2", ov1, 1);
        chk("ones_data", $signed(od1), 9);
        chk("ones_sat", os1, 0);
        @(posedge clk); #1;
        chk("ones_drop", ov1, 0);

        // four channels of 10*2: t = 720 - 20 = 700, (700+2)>>2 = 175 -> 127 saturated
        bias = -32'sd20;
        sh = 5'd2;
        for (int i = 0; i < 4; i++) begin
            chk("ch_seq", ch4, i);
            send(1'b1, {9{8'd10}}, {9{8'd2}});
        end
        chk("ch_wrap", ch4, 0);
        wait_ov(1'b1);
        chk("c4_data", $signed(od4), 127);
        chk("c4_sat", os4, 1);
        @(posedge clk); #1;

        // -5*3*9 = -135
        bias = '0;
        one1("neg_s1", 5'd1, 1'b0, -67, 0);
        one1("neg_s0", 5'd0, 1'b0, -128, 1);
        one1("neg_relu", 5'd0, 1'b1, 0, 0);

        // backpressure: 8-window stream, out_ready low for 5 cycles mid-stream
        bias = 32'sd3;
        sh = 5'd1;
        relu = 1'b0;
        @(posedge clk); #1;
        fork
            begin
                int i = 0;
                int n = 0;
                bit rdy;
                while (i < 8 && n < 100) begin
                    pix = mkpix(i);
                    wgt = mkwgt(i);
                    v1 = 1'b1;
                    @(negedge clk);
                    rdy = ir1;
                    @(posedge clk);
                    #1;
                    n++;
                    if (rdy) i++;
                end
                v1 = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                int k = 0;
                int stalls = 0;
                logic [8:0] e;
                for (int c = 0; c < 100 && k < 8; c++) begin
                    @(negedge clk);
                    e = rq(dot(mkpix(k), mkwgt(k)) + 3, 1, 1'b0);
                    if (ov1 && out_ready) begin
                        chk("bp_data", $signed(od1), $signed(e[7:0]));
                        chk("bp_sat", os1, e[8]);
                        k++;
                    end else if (ov1) begin
                        chk("bp_inrdy", ir1, 0);
                        chk("bp_hold", $signed(od1), $signed(e[7:0]));
                        stalls++;
                    end
                end
                chk("bp_count", k, 8);
                chk("bp_stalls", stalls, 5);
            end
        join
        repeat (4) begin
            @(negedge clk);
            chk("bp_extra", ov1, 0);
        end
        @(posedge clk); #1;

        // same frames back-to-back and with random bubbles
        bias = 32'sd5;
        sh = 5'd3;
        frame4("b2b_a", 20, 1'b0);
        frame4("b2b_b", 24, 1'b0);
        frame4("gap_a", 20, 1'b1);
        frame4("gap_b", 24, 1'b1);

        // reset after 2 of 4 beats, with those beats still in flight
        send(1'b1, mkpix(40), mkwgt(40));
        send(1'b1, mkpix(41), mkwgt(41));
        chk("pre_rst_ch", ch4, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", ov4, 0);
        chk("mid_rst_od", od4, 0);
        chk("mid_rst_os", os4, 0);
        chk("mid_rst_ch", ch4, 0);
        chk("mid_rst_ir", ir4, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_rst_ov", ov4, 0);
        end
        frame4("post_rst", 42, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
